// File: rtl/mem_pkg.sv
// Shared constants, FSM state type and sizing helper for the word memory.
package mem_pkg;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 16;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/byte_lane.sv
// One byte of storage: async-reset flop with write enable and synchronous zero.
module byte_lane (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       en,
    input  logic       zero,
    input  logic [7:0] d,
    output logic [7:0] q
);

    // Zero wins over a write so the clear sweep cannot be overridden.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)  q <= '0;
        else if (zero) q <= '0;
        else if (en)   q <= d;
    end

endmodule

// File: rtl/word_memory.sv
// DEPTH x WIDTH flop register file: byte-enabled writes, two registered read
// ports with write-first bypass, valid bits with occupancy count, clear sweep.
module word_memory
    import mem_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int AW    = clog2(DEPTH),
    localparam int BE_W  = WIDTH / 8,
    localparam int CW    = clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [BE_W-1:0]  wr_be,
    output logic             wr_err,
    input  logic             rd0_en,
    input  logic [AW-1:0]    rd0_addr,
    output logic [WIDTH-1:0] rd0_data,
    output logic             rd0_hit,
    input  logic             rd1_en,
    input  logic [AW-1:0]    rd1_addr,
    output logic [WIDTH-1:0] rd1_data,
    output logic             rd1_hit,
    input  logic             clear,
    output logic             busy,
    output logic [CW-1:0]    count
);

    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);
    localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);

    state_t                  state_q, state_n;
    logic [AW-1:0]           idx_q, idx_n;
    logic [DEPTH-1:0]        valid;
    logic                    wr_ok, wr_set;
    logic [BE_W-1:0][7:0]    word_q [DEPTH];

    logic [1:0]              rd_en_v;
    logic [1:0][AW-1:0]      rd_addr_v;
    logic [1:0][WIDTH-1:0]   rd_word, rd_q;
    logic [1:0]              rd_hit_c, rd_hit_q;

    assign busy   = (state_q == CLEAR);
    assign wr_ok  = wr_en && !busy && !clear && ({1'b0, wr_addr} < DEPTH_L);
    assign wr_set = wr_ok && (wr_be != '0);

    for (genvar d = 0; d < DEPTH; d++) begin : g_word
        for (genvar b = 0; b < BE_W; b++) begin : g_byte
            byte_lane u_lane (
                .clk     (clk),
                .reset_n (reset_n),
                .en      (wr_ok && wr_be[b] && (wr_addr == AW'(d))),
                .zero    (busy && (idx_q == AW'(d))),
                .d       (wr_data[8*b +: 8]),
                .q       (word_q[d][b])
            );
        end
    end

    // Writes and the sweep never coincide (writes are dropped while busy),
    // so count moves by at most one per cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid  <= '0;
            count  <= '0;
            wr_err <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (busy && idx_q == AW'(i))           valid[i] <= 1'b0;
                else if (wr_set && wr_addr == AW'(i))  valid[i] <= 1'b1;
            end
            if (wr_set && !valid[wr_addr])  count <= count + CW'(1);
            else if (busy && valid[idx_q])  count <= count - CW'(1);
            wr_err <= wr_en && !wr_ok;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_n;
            idx_q   <= idx_n;
        end
    end

    always_comb begin
        state_n = state_q;
        idx_n   = idx_q;
        case (state_q)
            IDLE: begin
                if (clear) begin
                    state_n = CLEAR;
                    idx_n   = '0;
                end
            end
            CLEAR: begin
                if (idx_q == LAST) begin
                    state_n = IDLE;
                    idx_n   = '0;
                end else begin
                    idx_n = idx_q + AW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign rd_en_v   = {rd1_en, rd0_en};
    assign rd_addr_v = {rd1_addr, rd0_addr};

    // Out-of-range addresses match no entry and fall through to zero/miss.
    always_comb begin
        rd_word  = '0;
        rd_hit_c = '0;
        for (int p = 0; p < 2; p++) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rd_addr_v[p] == AW'(i)) begin
                    rd_word[p]  = word_q[i];
                    rd_hit_c[p] = valid[i];
                end
            end
            if (wr_ok && wr_addr == rd_addr_v[p]) begin
                for (int b = 0; b < BE_W; b++) begin
                    if (wr_be[b]) rd_word[p][8*b +: 8] = wr_data[8*b +: 8];
                end
                if (wr_be != '0) rd_hit_c[p] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_q     <= '0;
            rd_hit_q <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (rd_en_v[p]) begin
                    rd_q[p]     <= rd_word[p];
                    rd_hit_q[p] <= rd_hit_c[p];
                end
            end
        end
    end

    assign rd0_data = rd_q[0];
    assign rd1_data = rd_q[1];
    assign rd0_hit  = rd_hit_q[0];
    assign rd1_hit  = rd_hit_q[1];

    count_range_a: assert property (@(posedge clk) disable iff (!reset_n)
        count <= CW'(DEPTH));

endmodule

// File: doc/word_memory.md
Name: word_memory

Overview:
- Parametrised successor to the 8-bit latch store: a clocked DEPTH x WIDTH register-file memory.
- Features: per-byte write enables, two independent registered read ports, per-entry valid bits with an occupancy count, and a multi-cycle clear sweep.
- Sits between datapath producers and consumers as scratch storage; replaces the level-sensitive latch memory with edge-triggered flops.

Parameters:
- WIDTH, 16, data word width in bits; must be a multiple of 8.
- DEPTH, 16, number of words; 2..256.
- AW (localparam), clog2(DEPTH), address width.
- BE_W (localparam), WIDTH/8, number of byte enables.
- CW (localparam), clog2(DEPTH+1), occupancy count width.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- wr_en  in  1  write request.
- wr_addr  in  AW  write address.
- wr_data  in  WIDTH  write data.
- wr_be  in  BE_W  byte enables; bit i covers wr_data[8i+7:8i].
- wr_err  out  1  one-cycle pulse: the previous write was dropped.
- rd0_en, rd1_en  in  1  read requests.
- rd0_addr, rd1_addr  in  AW  read addresses.
- rd0_data, rd1_data  out  WIDTH  registered read data.
- rd0_hit, rd1_hit  out  1  registered valid bit of the entry that was read.
- clear  in  1  start a clear sweep (single-cycle pulse).
- busy  out  1  clear sweep in progress.
- count  out  CW  number of valid entries.

Behaviour:
- Reset (async, reset_n=0):
  - All storage words = 0; all valid bits = 0.
  - rdN_data = 0, rdN_hit = 0, wr_err = 0, busy = 0, count = 0.
  - FSM = IDLE, sweep index = 0.
  - Reset asserted mid-sweep aborts the sweep immediately.
- Write (takes effect at the clk edge). A write is accepted when wr_en=1, busy=0, clear=0 and wr_addr<DEPTH.
  - Only the lanes with wr_be set are updated.
  - The valid bit is set only if wr_be != 0.
  - count increments by 1 only if that entry was previously invalid.
  - wr_be=0 is a no-op and does not raise wr_err.
- Dropped write: wr_en=1 with busy=1, clear=1, or wr_addr>=DEPTH. Storage is unchanged; wr_err=1 in the following cycle only.
- Read (latency 1 cycle):
  - When rdN_en=1 at an edge, rdN_data and rdN_hit reflect that entry after the edge.
  - When rdN_en=0, rdN_data and rdN_hit hold their previous values.
  - Read with address >= DEPTH: data=0, hit=0.
- Read/write collision, same address, same edge, write accepted: the read returns the byte-merged new word and hit=1 (write-first bypass).
- Both read ports may target the same or different addresses concurrently, with no restriction.
- FSM states: IDLE, CLEAR.
  - IDLE→CLEAR on clear=1. busy=1 from the next cycle.
  - In CLEAR, one entry per cycle (index 0..DEPTH-1): word←0, valid←0, and count decrements if that entry was valid.
  - After index DEPTH-1 is cleared, the FSM returns to IDLE; busy is high for exactly DEPTH cycles.
  - clear asserted while busy is ignored.
  - Reads during CLEAR are permitted and return current contents; already-swept entries read 0 with hit 0.
- count never exceeds DEPTH and never underflows; an assertion covers both.

Decomposition:
- Shared package mem_pkg:
  - clog2 function;
  - FSM state enum {IDLE, CLEAR};
  - default WIDTH/DEPTH constants.
- Sub-module byte_lane: one 8-bit flop register with async active-low reset, enable and synchronous zero.
  - Instantiated DEPTH x BE_W times; directly generalises the per-bit store cell.
- Read ports, bypass, valid/count logic and the FSM stay in word_memory.

Test Plan (WIDTH=16, DEPTH=16):
- Reset, then read addr 5 on both ports → rd0_data=rd1_data=0x0000, hit=0, count=0.
- Write addr 3 data 0xBEEF be=11, then write addr 3 data 0x1234 be=01, then read addr 3 → 0xBE34, hit=1, count=1.
- Same edge: write addr 7 0xA5A5 be=11 and rd0 addr 7 → next cycle rd0_data=0xA5A5, hit=1; rd1 of addr 8 in the same cycle → 0x0000, hit=0.
- Fill addrs 0..15, count=16; pulse clear → busy high exactly 16 cycles, count falls 16→0. A write to addr 2 at sweep cycle 3 → wr_err=1 and addr 2 reads 0 afterwards.
- Write with wr_addr out of range: hold the design at DEPTH=12, write addr 13 → wr_err=1, count unchanged; read addr 13 → 0x0000, hit=0.
- Assert reset_n=0 mid-sweep at cycle 5 → busy=0, count=0 and all outputs 0 immediately (asynchronously); a write after release succeeds normally.
